serial_subtractor: RTL



---
 rtl/serial_subtractor_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 19 +
 rtl/serial_subtractor.sv | 121 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor_pkg
// Brief  : Shared FSM encoding and counter sizing for the bit-serial subtractor
// Rev    : 1.0
// ============================================================================
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // The counter indexes bits 0..width-1, and it is never narrower than one bit
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module : full_subtractor
// Brief  : One-bit combinational full subtractor (A - B - BIN)
// Rev    : 1.0
// ============================================================================
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic BIN,
    output logic D,
    output logic BOUT
);

    assign D    = A ^ B ^ BIN;
    assign BOUT = (~A & B) | (~(A ^ B) & BIN);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module : serial_subtractor
// Brief  : Bit-serial WIDTH-bit subtractor, LSB first, valid/ready start, DONE pulse
// Rev    : 1.0
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START_VALID,
    output logic             START_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             BIN,
    output logic [WIDTH-1:0] D,
    output logic             BOUT,
    output logic             DONE,
    output logic             BUSY
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    full_subtractor u_cell (
        .A    (a_sh[0]),
        .B    (b_sh[0]),
        .BIN  (br),
        .D    (cell_d),
        .BOUT (cell_bo)
    );

    // Result fills from the top so that after WIDTH shifts bit 0 sits at the LSB
    assign res_next = {cell_d, res[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    always_comb begin
        state_next  = state;
        START_READY = 1'b0;
        BUSY        = 1'b0;
        DONE        = 1'b0;
        case (state)
            IDLE: begin
                START_READY = 1'b1;
                if (START_VALID) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                BUSY = 1'b1;
                if (last_bit) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                BUSY       = 1'b1;
                DONE       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            D     <= '0;
            BOUT  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (START_VALID) begin
                        a_sh <= A;
                        b_sh <= B;
                        br   <= BIN;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    br   <= cell_bo;
                    res  <= res_next;
                    if (last_bit) begin
                        D    <= res_next;
                        BOUT <= cell_bo;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire
